// File: rtl/plic_hart_mexg_unit.sv
// rtl/plic_hart_mexg_unit.sv - per-hart machine exception gate: cross-domain S-irq pending/enable/control regs
// Optional holdoff rate limiter is built when PLIC_MEXG_HOLDOFF_EN is defined.
module plic_hart_mexg_unit #(
    parameter int NUM_IRQ        = 1024,
    parameter int NUM_DOMAIN     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 26,
    parameter logic [MEM_ADDR_WIDTH-1:0] BASE_ADDR = 'h20_0010,
    parameter int HOLDOFF_W      = 8,
    localparam int ID_W  = $clog2(NUM_IRQ),
    localparam int DID_W = (NUM_DOMAIN > 1) ? $clog2(NUM_DOMAIN) : 1
) (
    input  logic                                  free_running_clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  acc_en_i,
    input  logic                                  csb_i,
    input  logic [MEM_ADDR_WIDTH-1:0]             addr_i,
    input  logic                                  rwb_i,
    input  logic [DATA_WIDTH/8-1:0]               wm_i,
    input  logic [DATA_WIDTH-1:0]                 wdata_i,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  error_o,
    input  logic [DID_W-1:0]                      hart_did_i,
    input  logic [NUM_DOMAIN-1:0][ID_W-1:0]       sint_winner_id_i,
    output logic [NUM_DOMAIN-1:0]                 mexg_pend_o,
    output logic                                  mexg_irq_o
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_PEND = BASE_ADDR;
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_EN   = BASE_ADDR + MEM_ADDR_WIDTH'(4);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_CTRL = BASE_ADDR + MEM_ADDR_WIDTH'(8);

    logic [NUM_DOMAIN-1:0] raw_q, raw_d;
    logic [NUM_DOMAIN-1:0] pend_q, pend_d;
    logic [NUM_DOMAIN-1:0] en_q, en_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;
    logic                  irq_q, irq_pre;

    logic [DATA_WIDTH-1:0] bmask, wmasked;
    logic                  hit_pend, hit_en, hit_ctrl, hit;
    logic                  wr_ok, rd_ok, w1c_wr;
    logic [NUM_DOMAIN-1:0] w1c;
    logic                  hold_zero;
    logic                  unused_bits;

    always_comb begin
        bmask = '0;
        for (int b = 0; b < NB; b++) begin
            bmask[b*8 +: 8] = {8{wm_i[b]}};
        end
    end

    assign wmasked  = wdata_i & bmask;
    assign hit_pend = !csb_i && (addr_i == ADDR_PEND);
    assign hit_en   = !csb_i && (addr_i == ADDR_EN);
    assign hit_ctrl = !csb_i && (addr_i == ADDR_CTRL);
    assign hit      = hit_pend || hit_en || hit_ctrl;
    assign wr_ok    = hit && acc_en_i && rwb_i;
    assign rd_ok    = hit && acc_en_i && !rwb_i;
    // Writes to PEND only act as W1C in sticky mode; in level mode they are dropped.
    assign w1c_wr   = wr_ok && hit_pend && mode_q;
    assign w1c      = w1c_wr ? wmasked[NUM_DOMAIN-1:0] : '0;

    always_comb begin
        raw_d = '0;
        for (int i = 0; i < NUM_DOMAIN; i++) begin
            raw_d[i] = (sint_winner_id_i[i] != '0) && (hart_did_i != DID_W'(i));
        end
    end

    // Raw set is OR-ed after the clear so a same-cycle set beats the W1C.
    assign pend_d = mode_q ? ((pend_q & ~w1c) | raw_q) : raw_q;

    assign en_d = (wr_ok && hit_en)
                ? ((en_q & ~bmask[NUM_DOMAIN-1:0]) | wmasked[NUM_DOMAIN-1:0])
                : en_q;

    assign mode_d  = (wr_ok && hit_ctrl && wm_i[0]) ? wdata_i[0] : mode_q;
    assign error_d = hit && !acc_en_i;

`ifdef PLIC_MEXG_HOLDOFF_EN
    logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
    logic [HOLDOFF_W-1:0] hold_cnt_q, hold_cnt_d;
    logic                 hold_load;

    assign hold_zero = (hold_cnt_q == '0);
    assign holdoff_d = (wr_ok && hit_ctrl)
                     ? ((holdoff_q & ~bmask[8 +: HOLDOFF_W]) | wmasked[8 +: HOLDOFF_W])
                     : holdoff_q;
    // Only a fall caused by pending going away rearms; a fall caused by the
    // countdown itself must not restart it.
    assign hold_load  = w1c_wr || (irq_q && !irq_pre && hold_zero);
    assign hold_cnt_d = hold_load ? holdoff_q
                      : (hold_zero ? '0 : hold_cnt_q - HOLDOFF_W'(1));

    always_ff @(posedge free_running_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            holdoff_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            holdoff_q  <= holdoff_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign hold_zero = 1'b1;
`endif

    assign irq_pre = (|(pend_q & en_q)) && hold_zero;

    always_comb begin
        rdata_d = '0;
        if (rd_ok) begin
            if (hit_pend) begin
                rdata_d[NUM_DOMAIN-1:0] = pend_q;
            end else if (hit_en) begin
                rdata_d[NUM_DOMAIN-1:0] = en_q;
            end else begin
                rdata_d[0] = mode_q;
`ifdef PLIC_MEXG_HOLDOFF_EN
                rdata_d[8 +: HOLDOFF_W] = holdoff_q;
`endif
            end
        end
    end

    always_ff @(posedge free_running_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            raw_q   <= '0;
            pend_q  <= '0;
            en_q    <= '1;
            mode_q  <= 1'b0;
            rdata_q <= '0;
            error_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            raw_q   <= raw_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            irq_q   <= irq_pre;
        end
    end

    assign unused_bits = ^{wmasked, wdata_i};

    assign rdata_o     = rdata_q;
    assign error_o     = error_q;
    assign mexg_pend_o = pend_q;
    assign mexg_irq_o  = irq_q;

endmodule
